cu_sequencer: RTL

CU_SEQUENCER -- requirements
Module: cu_sequencer

---
 rtl/cu_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/cu_sequencer.sv
// Control-unit sequencer: fetch/decode/execute FSM that drives the datapath control word.
// The opcode is latched in FETCH3; CON is decoded from the current state and that opcode.
module cu_sequencer (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] MBR_IN,
    input  logic        MEM_RDY,
    input  logic        zflag,
    output logic [31:0] CON,
    output logic [3:0]  STATE,
    output logic        HALTED
);

    typedef enum logic [3:0] {
        StFetch1 = 4'd0,
        StFetch2 = 4'd1,
        StFetch3 = 4'd2,
        StDecode = 4'd3,
        StExec1  = 4'd4,
        StExec2  = 4'd5,
        StExec3  = 4'd6,
        StExec4  = 4'd7,
        StExec5  = 4'd8,
        StStore2 = 4'd9,
        StStore3 = 4'd10,
        StHalt   = 4'd15
    } state_e;

    localparam logic [7:0] OpHalt  = 8'h00;
    localparam logic [7:0] OpStore = 8'h01;
    localparam logic [7:0] OpLoad  = 8'h02;
    localparam logic [7:0] OpAdd   = 8'h03;
    localparam logic [7:0] OpSub   = 8'h04;
    localparam logic [7:0] OpMpy   = 8'h05;
    localparam logic [7:0] OpDiv   = 8'h06;
    localparam logic [7:0] OpAnd   = 8'h07;
    localparam logic [7:0] OpOr    = 8'h08;
    localparam logic [7:0] OpNot   = 8'h09;
    localparam logic [7:0] OpShl   = 8'h0A;
    localparam logic [7:0] OpShr   = 8'h0B;
    localparam logic [7:0] OpJmp   = 8'h0C;
    localparam logic [7:0] OpJz    = 8'h0D;

    state_e      state_q, state_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [3:0]  alu_op;
    logic        is_alu;
    logic        is_shift;
    logic [31:0] con;

    // The address byte is consumed by the datapath, not by the sequencer.
    logic unused_addr;
    assign unused_addr = ^MBR_IN[7:0];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= StFetch1;
            opcode_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    // Opcode classification and ALU operation select.
    always_comb begin
        alu_op   = 4'd0;
        is_alu   = 1'b1;
        is_shift = 1'b0;
        unique case (opcode_q)
            OpLoad: alu_op = 4'd7;
            OpAdd:  alu_op = 4'd0;
            OpSub:  alu_op = 4'd1;
            OpMpy:  alu_op = 4'd2;
            OpDiv:  alu_op = 4'd3;
            OpAnd:  alu_op = 4'd4;
            OpOr:   alu_op = 4'd5;
            OpNot:  alu_op = 4'd6;
            OpShl: begin
                alu_op   = 4'd8;
                is_shift = 1'b1;
            end
            OpShr: begin
                alu_op   = 4'd9;
                is_shift = 1'b1;
            end
            default: is_alu = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        unique case (state_q)
            StFetch1: state_d = StFetch2;
            StFetch2: if (MEM_RDY) state_d = StFetch3;
            StFetch3: begin
                opcode_d = MBR_IN[15:8];
                state_d  = StDecode;
            end
            StDecode: begin
                if (opcode_q == OpHalt) begin
                    state_d = StHalt;
                end else if (is_shift) begin
                    // Shifts operate on ACC alone, so there is no operand fetch.
                    state_d = StExec4;
                end else if (is_alu || opcode_q == OpStore) begin
                    state_d = StExec1;
                end else begin
                    state_d = StFetch1;
                end
            end
            StExec1:  state_d = (opcode_q == OpStore) ? StStore2 : StExec2;
            StExec2:  if (MEM_RDY) state_d = StExec3;
            StExec3:  state_d = StExec4;
            StExec4:  state_d = StExec5;
            StExec5:  state_d = StFetch1;
            StStore2: state_d = StStore3;
            StStore3: if (MEM_RDY) state_d = StFetch1;
            StHalt:   state_d = StHalt;
            default:  state_d = StFetch1;
        endcase
    end

    always_comb begin
        con = 32'h0000_0000;
        unique case (state_q)
            StFetch1: con[1] = 1'b1;
            StFetch2: begin
                con[2] = 1'b1;
                con[0] = MEM_RDY;
            end
            StFetch3: con[3] = 1'b1;
            StDecode: begin
                if (opcode_q == OpJmp) begin
                    con[11] = 1'b1;
                end else if (opcode_q == OpJz) begin
                    con[11] = zflag;
                end
            end
            StExec1:  con[4] = 1'b1;
            StExec2:  con[2] = 1'b1;
            StExec3:  con[5] = 1'b1;
            StExec4: begin
                con[7:6]   = 2'b11;
                con[19:16] = alu_op;
            end
            StExec5:  con[8] = 1'b1;
            StStore2: con[9] = 1'b1;
            StStore3: con[10] = 1'b1;
            default:  con = 32'h0000_0000;
        endcase
    end

    assign CON    = con;
    assign STATE  = state_q;
    assign HALTED = (state_q == StHalt);

endmodule
